// File: rtl/tow_push_arbiter.sv
// Tug-of-war push front end: synchronises/edge-detects pbl/pbr, emits one move or tie pulse per round, then locks out.
// Optional macro TOW_DEBOUNCE_EN adds a DB_CYCLES stability filter after each synchroniser.
module tow_push_arbiter #(
    parameter int unsigned LOCKOUT_CYCLES = 8,
    parameter int unsigned DB_CYCLES      = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic pbl,
    input  logic pbr,
    input  logic busy,
    input  logic game_over,
    output logic mv_l,
    output logic mv_r,
    output logic tie,
    output logic armed
);

    if (LOCKOUT_CYCLES < 1 || LOCKOUT_CYCLES > 65535 || DB_CYCLES < 1 || DB_CYCLES > 65535) begin : g_bad_param
        $error("tow_push_arbiter: LOCKOUT_CYCLES and DB_CYCLES must be in 1..65535");
    end

    localparam logic [15:0] LOCK_LOAD = 16'(LOCKOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_ARMED    = 2'd0,
        S_HOLD     = 2'd1,
        S_LOCKOUT  = 2'd2,
        S_GAMEOVER = 2'd3
    } state_t;

    // Bit 0 is the left button, bit 1 the right button throughout.
    logic [1:0]  sync1_q, sync2_q;
    logic [1:0]  lvl;
    logic [1:0]  lvl_q;
    logic [1:0]  edge_q;
    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        mv_l_q, mv_l_d;
    logic        mv_r_q, mv_r_d;
    logic        tie_q, tie_d;
    logic        armed_q, armed_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {pbr, pbl};
            sync2_q <= sync1_q;
        end
    end

`ifdef TOW_DEBOUNCE_EN
    localparam logic [15:0] DB_LAST = 16'(DB_CYCLES - 1);

    logic [1:0]       filt_q;
    logic [1:0][15:0] db_cnt_q;

    // The filtered level only follows after DB_CYCLES consecutive samples at the new value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_q   <= '0;
            db_cnt_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_LAST) begin
                    filt_q[i]   <= sync2_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + 16'd1;
                end
            end
        end
    end

    assign lvl = filt_q;
`else
    assign lvl = sync2_q;
`endif

    // Edges are registered so the FSM decides on a clean, aligned pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl_q  <= '0;
            edge_q <= '0;
        end else begin
            lvl_q  <= lvl;
            edge_q <= lvl & ~lvl_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mv_l_d  = 1'b0;
        mv_r_d  = 1'b0;
        tie_d   = 1'b0;
        case (state_q)
            S_ARMED: begin
                if (game_over) begin
                    state_d = S_GAMEOVER;
                end else if (edge_q != 2'b00) begin
                    state_d = S_HOLD;
                    mv_l_d  = (edge_q == 2'b01);
                    mv_r_d  = (edge_q == 2'b10);
                    tie_d   = (edge_q == 2'b11);
                end
            end
            S_HOLD: begin
                if (game_over) begin
                    state_d = S_GAMEOVER;
                end else if (lvl == 2'b00 && !busy) begin
                    state_d = S_LOCKOUT;
                    cnt_d   = LOCK_LOAD;
                end
            end
            S_LOCKOUT: begin
                if (game_over) begin
                    state_d = S_GAMEOVER;
                end else if (lvl != 2'b00 || busy) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end else if (cnt_q == 16'd0) begin
                    state_d = S_ARMED;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_GAMEOVER: begin
                state_d = S_GAMEOVER;
            end
            default: begin
                state_d = S_HOLD;
            end
        endcase
        armed_d = (state_d == S_ARMED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_HOLD;
            cnt_q   <= '0;
            mv_l_q  <= 1'b0;
            mv_r_q  <= 1'b0;
            tie_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mv_l_q  <= mv_l_d;
            mv_r_q  <= mv_r_d;
            tie_q   <= tie_d;
            armed_q <= armed_d;
        end
    end

    assign mv_l  = mv_l_q;
    assign mv_r  = mv_r_q;
    assign tie   = tie_q;
    assign armed = armed_q;

endmodule
